bank_biu_sched: RTL and testbench



---
 rtl/bank_biu_sched.sv | 169 ++++++++++++++++
 tb/tb_bank_biu_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bank_biu_sched.sv
// Per-bank scheduler: arbitrates HTU refill reads against eviction writes, sequences AR / AW+W
// onto the BIU, and tracks outstanding transactions per set_way.
module bank_biu_sched #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned MAX_RD     = 4,
    parameter int unsigned MAX_WR     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  htu_rd_valid_i,
    output logic                  htu_rd_ready_o,
    input  logic [ADDR_WIDTH-6:0] htu_rd_addr_i,
    input  logic [5:0]            htu_rd_set_way_i,
    input  logic                  htu_wr_valid_i,
    output logic                  htu_wr_ready_o,
    input  logic [ADDR_WIDTH-6:0] htu_wr_addr_i,
    input  logic [5:0]            htu_wr_set_way_i,
    output logic                  sched_biu_arvalid_o,
    input  logic                  sched_biu_arready_i,
    output logic [ADDR_WIDTH-6:0] sched_biu_araddr_o,
    output logic                  sched_biu_awvalid_o,
    input  logic                  sched_biu_awready_i,
    output logic [ADDR_WIDTH-6:0] sched_biu_awaddr_o,
    output logic [5:0]            sched_biu_set_way_o,
    input  logic                  sc_valid_i,
    output logic                  sc_ready_o,
    output logic                  sched_biu_wvalid_o,
    input  logic                  sched_biu_wready_i,
    input  logic                  biu_isu_rvalid_i,
    input  logic                  biu_isu_rready_i,
    input  logic                  biu_axi3_rlast_i,
    input  logic [ID_WIDTH-1:0]   biu_isu_rid_i,
    input  logic [1:0]            biu_axi3_rresp_i,
    input  logic                  biu_axi3_bvalid_i,
    output logic                  biu_axi3_bready_o,
    input  logic [ID_WIDTH-1:0]   biu_axi3_bid_i,
    input  logic [1:0]            biu_axi3_bresp_i,
    input  logic                  err_clr_i,
    output logic                  sched_err_o,
    output logic [5:0]            sched_err_set_way_o,
    output logic                  sched_idle_o
);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, AR, AWW} state_t;

    state_t        state;
    logic [63:0]   busy;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          rr_last_wr;
    logic          aw_done;
    logic          w_done;

    logic       rd_elig, wr_elig, grant_rd, grant_wr;
    logic       rd_acc, wr_acc;
    logic [5:0] rid_sw, bid_sw;
    logic       rd_cmp, wr_cmp, rd_dec, wr_dec, rd_err, wr_err;
    logic       aw_hs, w_hs;
    logic       unused_id_hi;

    assign unused_id_hi = ^{biu_isu_rid_i[ID_WIDTH-1:6], biu_axi3_bid_i[ID_WIDTH-1:6]};

    // Arbitration on registered busy/counters; both eligible alternates by rr_last_wr
    assign rd_elig  = htu_rd_valid_i & ~busy[htu_rd_set_way_i] & (rd_cnt < CW'(MAX_RD));
    assign wr_elig  = htu_wr_valid_i & ~busy[htu_wr_set_way_i] & (wr_cnt < CW'(MAX_WR));
    assign grant_wr = wr_elig & (~rd_elig | ~rr_last_wr);
    assign grant_rd = rd_elig & ~grant_wr;

    assign htu_rd_ready_o = (state == IDLE) & grant_rd;
    assign htu_wr_ready_o = (state == IDLE) & grant_wr;
    assign rd_acc         = htu_rd_ready_o;
    assign wr_acc         = htu_wr_ready_o;

    assign sched_biu_wvalid_o = (state == AWW) & sc_valid_i & ~w_done;
    assign sc_ready_o         = (state == AWW) & sched_biu_wready_i & ~w_done;
    assign aw_hs              = sched_biu_awvalid_o & sched_biu_awready_i;
    assign w_hs               = sched_biu_wvalid_o & sched_biu_wready_i;

    // A completion only retires a transaction if its set_way is actually outstanding
    assign rid_sw = biu_isu_rid_i[5:0];
    assign bid_sw = biu_axi3_bid_i[5:0];
    assign rd_cmp = biu_isu_rvalid_i & biu_isu_rready_i & biu_axi3_rlast_i;
    assign wr_cmp = biu_axi3_bvalid_i & biu_axi3_bready_o;
    assign rd_dec = rd_cmp & busy[rid_sw] & (rd_cnt != '0);
    assign wr_dec = wr_cmp & busy[bid_sw] & (wr_cnt != '0);
    assign rd_err = rd_cmp & ((biu_axi3_rresp_i != 2'b00) | ~rd_dec);
    assign wr_err = wr_cmp & ((biu_axi3_bresp_i != 2'b00) | ~wr_dec);

    assign sched_idle_o = (state == IDLE) & (rd_cnt == '0) & (wr_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            busy                <= '0;
            rd_cnt              <= '0;
            wr_cnt              <= '0;
            rr_last_wr          <= 1'b0;
            aw_done             <= 1'b0;
            w_done              <= 1'b0;
            sched_biu_arvalid_o <= 1'b0;
            sched_biu_awvalid_o <= 1'b0;
            sched_biu_araddr_o  <= '0;
            sched_biu_awaddr_o  <= '0;
            sched_biu_set_way_o <= '0;
            biu_axi3_bready_o   <= 1'b0;
            sched_err_o         <= 1'b0;
            sched_err_set_way_o <= '0;
        end else begin
            biu_axi3_bready_o <= 1'b1;
            rd_cnt            <= rd_cnt + CW'(rd_acc) - CW'(rd_dec);
            wr_cnt            <= wr_cnt + CW'(wr_acc) - CW'(wr_dec);

            // Clears first, then the set: an accepted set_way is never busy, so no overlap
            begin
                logic [63:0] busy_n;
                busy_n = busy;
                if (rd_dec) busy_n[rid_sw] = 1'b0;
                if (wr_dec) busy_n[bid_sw] = 1'b0;
                if (rd_acc) busy_n[htu_rd_set_way_i] = 1'b1;
                if (wr_acc) busy_n[htu_wr_set_way_i] = 1'b1;
                busy <= busy_n;
            end

            if (rd_err | wr_err) begin
                sched_err_o <= 1'b1;
                if (~sched_err_o | err_clr_i)
                    sched_err_set_way_o <= rd_err ? rid_sw : bid_sw;
            end else if (err_clr_i) begin
                sched_err_o <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (wr_acc) begin
                        sched_biu_awaddr_o  <= htu_wr_addr_i;
                        sched_biu_set_way_o <= htu_wr_set_way_i;
                        sched_biu_awvalid_o <= 1'b1;
                        aw_done             <= 1'b0;
                        w_done              <= 1'b0;
                        rr_last_wr          <= 1'b1;
                        state               <= AWW;
                    end else if (rd_acc) begin
                        sched_biu_araddr_o  <= htu_rd_addr_i;
                        sched_biu_set_way_o <= htu_rd_set_way_i;
                        sched_biu_arvalid_o <= 1'b1;
                        rr_last_wr          <= 1'b0;
                        state               <= AR;
                    end
                end
                AR: begin
                    if (sched_biu_arready_i) begin
                        sched_biu_arvalid_o <= 1'b0;
                        state               <= IDLE;
                    end
                end
                AWW: begin
                    if (aw_hs) sched_biu_awvalid_o <= 1'b0;
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_biu_sched.sv
// Randomized bench for bank_biu_sched against a transaction-level model of the scheduler rules.
module tb_bank_biu_sched;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 8;
    localparam int unsigned MAX_RD = 2;
    localparam int unsigned MAX_WR = 2;
    localparam int unsigned LW = AW - 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rd_valid, wr_valid, arready, awready, sc_valid, wready;
    logic [LW-1:0] rd_addr, wr_addr;
    logic [5:0]    rd_sw, wr_sw;
    logic          rvalid, rready, rlast, bvalid, err_clr;
    logic [IW-1:0] rid, bid;
    logic [1:0]    rresp, bresp;

    logic          rd_ready, wr_ready, arvalid, awvalid, sc_ready, wvalid, bready, err, idle;
    logic [LW-1:0] araddr, awaddr;
    logic [5:0]    set_way, err_sw;

    bank_biu_sched #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_RD(MAX_RD), .MAX_WR(MAX_WR)) dut (
        .clk_i(clk), .rst_i(rst),
        .htu_rd_valid_i(rd_valid), .htu_rd_ready_o(rd_ready),
        .htu_rd_addr_i(rd_addr), .htu_rd_set_way_i(rd_sw),
        .htu_wr_valid_i(wr_valid), .htu_wr_ready_o(wr_ready),
        .htu_wr_addr_i(wr_addr), .htu_wr_set_way_i(wr_sw),
        .sched_biu_arvalid_o(arvalid), .sched_biu_arready_i(arready),
        .sched_biu_araddr_o(araddr),
        .sched_biu_awvalid_o(awvalid), .sched_biu_awready_i(awready),
        .sched_biu_awaddr_o(awaddr), .sched_biu_set_way_o(set_way),
        .sc_valid_i(sc_valid), .sc_ready_o(sc_ready),
        .sched_biu_wvalid_o(wvalid), .sched_biu_wready_i(wready),
        .biu_isu_rvalid_i(rvalid), .biu_isu_rready_i(rready), .biu_axi3_rlast_i(rlast),
        .biu_isu_rid_i(rid), .biu_axi3_rresp_i(rresp),
        .biu_axi3_bvalid_i(bvalid), .biu_axi3_bready_o(bready),
        .biu_axi3_bid_i(bid), .biu_axi3_bresp_i(bresp),
        .err_clr_i(err_clr), .sched_err_o(err), .sched_err_set_way_o(err_sw),
        .sched_idle_o(idle)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: outstanding set_ways, per-kind counts, and the one transaction being issued
    bit            m_init = 0;
    bit            m_busy[64];
    bit            m_is_wr[64];
    int            m_rd, m_wr;
    bit            m_rr;
    int            m_ph;          // 0 none in issue, 1 read issuing, 2 write issuing
    logic [LW-1:0] m_araddr, m_awaddr;
    logic [5:0]    m_sw, m_esw;
    bit            m_awd, m_wd, m_err, m_bready;

    task automatic model_reset();
        foreach (m_busy[i]) begin m_busy[i] = 0; m_is_wr[i] = 0; end
        m_rd = 0; m_wr = 0; m_rr = 0; m_ph = 0;
        m_araddr = '0; m_awaddr = '0; m_sw = '0; m_esw = '0;
        m_awd = 0; m_wd = 0; m_err = 0; m_bready = 0;
    endtask

    task automatic idle_inputs();
        rst = 0; rd_valid = 0; wr_valid = 0; arready = 0; awready = 0; sc_valid = 0; wready = 0;
        rd_addr = '0; wr_addr = '0; rd_sw = '0; wr_sw = '0;
        rvalid = 0; rready = 0; rlast = 0; bvalid = 0; err_clr = 0;
        rid = '0; bid = '0; rresp = '0; bresp = '0;
    endtask

    task automatic cycle();
        bit rd_ok, wr_ok, g_rd, g_wr, e_wv, e_scr;
        bit rd_good, wr_good, rd_e, wr_e, aw_hs, w_hs;
        #1;
        rd_ok = rd_valid && !m_busy[rd_sw] && (m_rd < int'(MAX_RD));
        wr_ok = wr_valid && !m_busy[wr_sw] && (m_wr < int'(MAX_WR));
        g_wr  = (m_ph == 0) && wr_ok && (!rd_ok || !m_rr);
        g_rd  = (m_ph == 0) && rd_ok && !g_wr;
        e_wv  = (m_ph == 2) && sc_valid && !m_wd;
        e_scr = (m_ph == 2) && wready && !m_wd;
        if (m_init) begin
            chk("rd_ready", 64'(rd_ready), 64'(g_rd));
            chk("wr_ready", 64'(wr_ready), 64'(g_wr));
            chk("wvalid", 64'(wvalid), 64'(e_wv));
            chk("sc_ready", 64'(sc_ready), 64'(e_scr));
        end
        if (rst) begin
            model_reset();
            m_init = 1;
        end else if (m_init) begin
            rd_good = rvalid && rready && rlast && m_busy[rid[5:0]] && m_rd > 0;
            wr_good = bvalid && m_bready && m_busy[bid[5:0]] && m_wr > 0;
            rd_e = rvalid && rready && rlast && (rresp != 0 || !rd_good);
            wr_e = bvalid && m_bready && (bresp != 0 || !wr_good);
            if (rd_e || wr_e) begin
                if (!m_err || err_clr) m_esw = rd_e ? rid[5:0] : bid[5:0];
                m_err = 1;
            end else if (err_clr) m_err = 0;
            if (rd_good) begin m_busy[rid[5:0]] = 0; m_rd--; end
            if (wr_good) begin m_busy[bid[5:0]] = 0; m_wr--; end
            case (m_ph)
                0: if (g_wr) begin
                       m_busy[wr_sw] = 1; m_is_wr[wr_sw] = 1; m_wr++; m_rr = 1;
                       m_awaddr = wr_addr; m_sw = wr_sw; m_ph = 2; m_awd = 0; m_wd = 0;
                   end else if (g_rd) begin
                       m_busy[rd_sw] = 1; m_is_wr[rd_sw] = 0; m_rd++; m_rr = 0;
                       m_araddr = rd_addr; m_sw = rd_sw; m_ph = 1;
                   end
                1: if (arready) m_ph = 0;
                default: begin
                    aw_hs = !m_awd && awready;
                    w_hs  = e_wv && wready;
                    m_awd = m_awd || aw_hs;
                    m_wd  = m_wd || w_hs;
                    if (m_awd && m_wd) m_ph = 0;
                end
            endcase
            m_bready = 1;
        end
        @(posedge clk);
        #1;
        if (m_init) begin
            chk("arvalid", 64'(arvalid), 64'(m_ph == 1));
            chk("awvalid", 64'(awvalid), 64'(m_ph == 2 && !m_awd));
            chk("araddr", 64'(araddr), 64'(m_araddr));
            chk("awaddr", 64'(awaddr), 64'(m_awaddr));
            chk("set_way", 64'(set_way), 64'(m_sw));
            chk("bready", 64'(bready), 64'(m_bready));
            chk("err", 64'(err), 64'(m_err));
            chk("err_sw", 64'(err_sw), 64'(m_esw));
            chk("idle", 64'(idle), 64'(m_ph == 0 && m_rd == 0 && m_wr == 0));
        end
    endtask

    function automatic logic [5:0] pick_out(input bit want_wr);
        int cand[$];
        for (int i = 0; i < 64; i++)
            if (m_busy[i] && (m_is_wr[i] == want_wr)) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 19) != 0)
            return 6'(cand[$urandom_range(0, cand.size() - 1)]);
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic drive_rand();
        rst      = ($urandom_range(0, 299) == 0);
        rd_valid = ($urandom_range(0, 9) < 6);
        wr_valid = ($urandom_range(0, 9) < 5);
        rd_addr  = LW'($urandom);
        wr_addr  = LW'($urandom);
        rd_sw    = 6'($urandom_range(0, 11));
        wr_sw    = 6'($urandom_range(0, 11));
        arready  = ($urandom_range(0, 1) == 1);
        awready  = ($urandom_range(0, 1) == 1);
        sc_valid = ($urandom_range(0, 1) == 1);
        wready   = ($urandom_range(0, 1) == 1);
        rvalid   = ($urandom_range(0, 2) == 0);
        rready   = ($urandom_range(0, 3) != 0);
        rlast    = ($urandom_range(0, 2) != 0);
        rid      = {2'($urandom), pick_out(0)};
        rresp    = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        bvalid   = ($urandom_range(0, 2) == 0);
        bid      = {2'($urandom), pick_out(1)};
        bresp    = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        err_clr  = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        cycle();
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_bready", 64'(bready), 64'd0);
        rst = 0;
        cycle();
        chk("bready_after_reset", 64'(bready), 64'd1);

        // Read with AR back-pressure, then its final R beat
        rd_valid = 1; rd_addr = LW'(32'h1234567); rd_sw = 6'd5;
        cycle();
        rd_valid = 0;
        repeat (3) cycle();
        chk("araddr_held", 64'(araddr), 64'h1234567);
        arready = 1; cycle(); arready = 0;
        rvalid = 1; rready = 1; rlast = 1; rid = 8'd5;
        cycle();
        idle_inputs();
        cycle();
        chk("idle_after_read", 64'(idle), 64'd1);

        // Concurrent read sw3 / write sw9; W beat lands before AW
        rd_valid = 1; rd_sw = 6'd3; rd_addr = LW'(32'h100);
        wr_valid = 1; wr_sw = 6'd9; wr_addr = LW'(32'h200);
        cycle();
        chk("write_first_sw", 64'(set_way), 64'd9);
        wr_valid = 0; sc_valid = 1; wready = 1;
        cycle();
        sc_valid = 0; wready = 0;
        repeat (2) cycle();
        awready = 1; cycle(); awready = 0;
        cycle();
        rd_valid = 0; arready = 1; cycle(); arready = 0;

        // Error on write 9, later read error on 3 keeps 9, clear, spurious bid 20
        bvalid = 1; bid = 8'd9; bresp = 2'b10; cycle(); bvalid = 0; bresp = 0;
        chk("err_sw_first", 64'(err_sw), 64'd9);
        rvalid = 1; rready = 1; rlast = 1; rid = 8'd3; rresp = 2'b10; cycle();
        idle_inputs(); cycle();
        err_clr = 1; cycle(); err_clr = 0;
        bvalid = 1; bid = 8'd20; cycle(); idle_inputs(); cycle();

        // Same-cycle AW and W, then reset mid-write after AW only
        wr_valid = 1; wr_sw = 6'd12; wr_addr = LW'(32'h3ff); cycle(); wr_valid = 0;
        awready = 1; sc_valid = 1; wready = 1; cycle(); idle_inputs(); cycle();
        wr_valid = 1; wr_sw = 6'd10; cycle(); wr_valid = 0;
        awready = 1; cycle(); awready = 0;
        rst = 1; cycle(); rst = 0; cycle();
        chk("idle_after_mid_reset", 64'(idle), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
